// File: rtl/piano_pkg.sv
// Shared types, note table and arithmetic helpers for the polyphonic square-wave synth.
// The RELEASE state is only entered when RELEASE_RAMP_EN is defined.
package piano_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, RELEASE} voice_state_t;

  localparam int NUM_NOTES = 10;

  // White keys C4..E5 at 50 MHz: round(25e6/f)-1 clock cycles per half period.
  localparam logic [18:0] HALF_PERIOD [0:9] = '{
    19'd95554, 19'd85130, 19'd75842, 19'd71585, 19'd63775,
    19'd56817, 19'd50618, 19'd47777, 19'd42565, 19'd37921
  };

  function automatic logic [18:0] half_period(input int unsigned k);
    if (k < NUM_NOTES) return HALF_PERIOD[k[3:0]];
    return '0;
  endfunction

  // Clamp x into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/poly_square_synth_if.sv
// Key input, voice status and valid/ready sample stream of the synth.
// master = tone generator side, slave = key source / codec write path.
interface poly_square_synth_if #(
  parameter int NUM_KEYS   = 10,
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 32
);
  logic [NUM_KEYS-1:0]        key_mask;
  logic                       sample_ready;
  logic                       sample_valid;
  logic signed [SAMPLE_W-1:0] sample;
  logic [NUM_VOICES-1:0]      voice_busy;
  logic                       overflow;

  modport master (
    input  key_mask, sample_ready,
    output sample_valid, sample, voice_busy, overflow
  );

  modport slave (
    output key_mask, sample_ready,
    input  sample_valid, sample, voice_busy, overflow
  );
endinterface

// File: rtl/poly_square_synth_tone_voice.sv
// One square-wave voice: state, half-period counter, phase and output level.
// With RELEASE_RAMP_EN defined a released voice decays its amplitude before going idle.
module tone_voice
  import piano_pkg::*;
#(
  parameter int CNT_W     = 19,
  parameter int KEY_W     = 4,
  parameter int SAMPLE_W  = 32,
  parameter int VOICE_AMP = 2_500_000
`ifdef RELEASE_RAMP_EN
  , parameter int RAMP_STEP = 64
`endif
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       grant,
  input  logic [KEY_W-1:0]           grant_key,
  input  logic [CNT_W-1:0]           grant_half,
  input  logic                       key_held,
  output voice_state_t               state,
  output logic [KEY_W-1:0]           key,
  output logic signed [SAMPLE_W-1:0] level
);

  localparam logic signed [SAMPLE_W-1:0] AMP = SAMPLE_W'(VOICE_AMP);

  voice_state_t     state_d;
  logic [CNT_W-1:0] cnt, cnt_d, half, half_d, cnt_tick;
  logic [KEY_W-1:0] key_d;
  logic             phase, phase_d, phase_tick, wrap;

`ifdef RELEASE_RAMP_EN
  localparam logic signed [SAMPLE_W-1:0] STEP = SAMPLE_W'(RAMP_STEP);
  logic signed [SAMPLE_W-1:0] amp, amp_d;
`else
  logic signed [SAMPLE_W-1:0] amp;
  assign amp = AMP;
`endif

  // Toggle period is half+1 cycles: the count runs 0..half inclusive.
  assign wrap       = (cnt == half);
  assign cnt_tick   = wrap ? '0 : cnt + CNT_W'(1);
  assign phase_tick = phase ^ wrap;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    phase_d = phase;
    key_d   = key;
    half_d  = half;
`ifdef RELEASE_RAMP_EN
    amp_d   = amp;
`endif
    unique case (state)
      IDLE: begin
        if (grant) begin
          state_d = PLAY;
          key_d   = grant_key;
          half_d  = grant_half;
          cnt_d   = '0;
          phase_d = 1'b1;
`ifdef RELEASE_RAMP_EN
          amp_d   = AMP;
`endif
        end
      end
      PLAY: begin
        cnt_d   = cnt_tick;
        phase_d = phase_tick;
        if (!key_held) begin
`ifdef RELEASE_RAMP_EN
          state_d = RELEASE;
`else
          state_d = IDLE;
`endif
        end
      end
      RELEASE: begin
`ifdef RELEASE_RAMP_EN
        cnt_d   = cnt_tick;
        phase_d = phase_tick;
        amp_d   = (amp > STEP) ? amp - STEP : '0;
        if (amp == '0) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      phase <= 1'b0;
`ifdef RELEASE_RAMP_EN
      amp   <= '0;
`endif
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      phase <= phase_d;
`ifdef RELEASE_RAMP_EN
      amp   <= amp_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    key  <= key_d;
    half <= half_d;
  end

  // An idle voice is silent rather than holding its last phase.
  always_comb begin
    level = '0;
    if (state != IDLE) level = phase ? amp : -amp;
  end

endmodule

// File: rtl/poly_square_synth.sv
// Polyphonic square-wave synth: key register, voice allocator, saturating mixer, output register.
// Optional release ramp per voice is enabled by defining RELEASE_RAMP_EN.
module poly_square_synth
  import piano_pkg::*;
#(
  parameter int NUM_KEYS   = 10,
  parameter int NUM_VOICES = 4,
  parameter int CNT_W      = 19,
  parameter int SAMPLE_W   = 32,
  parameter int VOICE_AMP  = 2_500_000
`ifdef RELEASE_RAMP_EN
  , parameter int RAMP_STEP = 64
`endif
) (
  input  logic                    CLOCK_50,
  input  logic                    resetn,
  poly_square_synth_if.master     bus
);

  localparam int KEY_W   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int VOICE_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int MIX_W   = SAMPLE_W + VOICE_W;

  logic [NUM_KEYS-1:0]        key_q, owned, pend;
  logic [NUM_VOICES-1:0]      grant, key_held, busy;
  voice_state_t               vstate [NUM_VOICES];
  logic [KEY_W-1:0]           vkey   [NUM_VOICES];
  logic signed [SAMPLE_W-1:0] vlevel [NUM_VOICES];
  logic [KEY_W-1:0]           sel_key;
  logic [VOICE_W-1:0]         sel_voice;
  logic                       has_key, has_voice, overflow_q;
  logic [CNT_W-1:0]           grant_half;
  logic signed [MIX_W-1:0]    mix;
  logic signed [SAMPLE_W-1:0] mix_sat;

  // Stage 1: key register
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) key_q <= '0;
    else         key_q <= bus.key_mask;
  end

  // Stage 2: allocator. Only PLAY voices own their key, so a releasing key can be re-struck.
  always_comb begin
    owned = '0;
    for (int v = 0; v < NUM_VOICES; v++)
      if (vstate[v] == PLAY) owned[vkey[v]] = 1'b1;
  end

  assign pend = key_q & ~owned;

  always_comb begin
    has_key   = 1'b0;
    sel_key   = '0;
    has_voice = 1'b0;
    sel_voice = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--)
      if (pend[k]) begin
        has_key = 1'b1;
        sel_key = KEY_W'(k);
      end
    for (int v = NUM_VOICES - 1; v >= 0; v--)
      if (vstate[v] == IDLE) begin
        has_voice = 1'b1;
        sel_voice = VOICE_W'(v);
      end
  end

  always_comb begin
    grant = '0;
    if (has_key && has_voice) grant[sel_voice] = 1'b1;
  end

  assign grant_half = CNT_W'(half_period(int'(sel_key)));

  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      key_held[v] = key_q[vkey[v]];
      busy[v]     = (vstate[v] != IDLE);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn)                    overflow_q <= 1'b0;
    else if (has_key && !has_voice) overflow_q <= 1'b1;
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    tone_voice #(
      .CNT_W    (CNT_W),
      .KEY_W    (KEY_W),
      .SAMPLE_W (SAMPLE_W),
      .VOICE_AMP(VOICE_AMP)
`ifdef RELEASE_RAMP_EN
      , .RAMP_STEP(RAMP_STEP)
`endif
    ) u_voice (
      .clk       (CLOCK_50),
      .resetn    (resetn),
      .grant     (grant[v]),
      .grant_key (sel_key),
      .grant_half(grant_half),
      .key_held  (key_held[v]),
      .state     (vstate[v]),
      .key       (vkey[v]),
      .level     (vlevel[v])
    );
  end

  // Stage 3: mixer and output register
  always_comb begin
    mix = '0;
    for (int v = 0; v < NUM_VOICES; v++) mix = mix + MIX_W'(vlevel[v]);
  end

  assign mix_sat = SAMPLE_W'(sat_signed(64'(mix), SAMPLE_W));

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      bus.sample_valid <= 1'b0;
      bus.sample       <= '0;
    end else if (!bus.sample_valid || bus.sample_ready) begin
      bus.sample_valid <= 1'b1;
      bus.sample       <= mix_sat;
    end
  end

  assign bus.voice_busy = busy;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_poly_square_synth.sv
// Bench for poly_square_synth: a 32-bit instance and a 16-bit saturating instance side by side.
module tb_poly_square_synth;

  typedef struct {
    int                 t;
    logic signed [63:0] v;
  } timed_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic signed [63:0] exp_q[$];
  timed_t             sb_q[$];

  always #10 clk = ~clk;

  poly_square_synth_if #(.NUM_KEYS(10), .NUM_VOICES(4), .SAMPLE_W(32)) bus32 ();
  poly_square_synth_if #(.NUM_KEYS(10), .NUM_VOICES(4), .SAMPLE_W(16)) bus16 ();

  poly_square_synth #(.SAMPLE_W(32)) dut32 (
    .CLOCK_50(clk), .resetn(resetn), .bus(bus32)
  );
  poly_square_synth #(.SAMPLE_W(16), .VOICE_AMP(20000)) dut16 (
    .CLOCK_50(clk), .resetn(resetn), .bus(bus16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic signed [63:0] e;
    resetn = 1'b0;
    bus32.key_mask = '1;
    bus16.key_mask = '1;
    bus32.sample_ready = 1'b1;
    bus16.sample_ready = 1'b1;
    repeat (3) tick();
    checks++; if (bus32.sample !== 32'sd0) begin errors++; $display("FAIL reset_sample got=%0d want=0", bus32.sample); end
    checks++; if (bus32.sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", bus32.sample_valid); end
    checks++; if (bus32.voice_busy !== 4'b0000) begin errors++; $display("FAIL reset_busy got=%b want=0000", bus32.voice_busy); end
    checks++; if (bus32.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b want=0", bus32.overflow); end
    checks++; if (bus16.sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid16 got=%b want=0", bus16.sample_valid); end
    // release reset with key 0 held: grant two edges later, sound one edge after that
    bus32.key_mask = 10'h001;
    bus16.key_mask = 10'h000;
    resetn = 1'b1;
    exp_q.push_back(64'sd0);
    exp_q.push_back(64'sd1);
    exp_q.push_back(64'sd2500000);
    tick();
    e = exp_q.pop_front();
    checks++; if (bus32.voice_busy !== e[3:0]) begin errors++; $display("FAIL release_busy_e0 got=%b want=%b", bus32.voice_busy, e[3:0]); end
    checks++; if (bus32.sample_valid !== 1'b1) begin errors++; $display("FAIL release_valid got=%b want=1", bus32.sample_valid); end
    tick();
    e = exp_q.pop_front();
    checks++; if (bus32.voice_busy !== e[3:0]) begin errors++; $display("FAIL release_busy_e1 got=%b want=%b", bus32.voice_busy, e[3:0]); end
    tick();
    e = exp_q.pop_front();
    checks++; if (bus32.sample !== e) begin errors++; $display("FAIL release_sample got=%0d want=%0d", bus32.sample, e); end
    bus32.key_mask = 10'h000;
    tick();
    tick();
    checks++; if (bus32.voice_busy !== 4'b0000) begin errors++; $display("FAIL keyup_busy got=%b want=0000", bus32.voice_busy); end
    tick();
    checks++; if (bus32.sample !== 32'sd0) begin errors++; $display("FAIL keyup_sample got=%0d want=0", bus32.sample); end
  endtask

  // A4 alone on the 32-bit instance; keys 8+9 on the 16-bit instance to hit both rails.
  task automatic test_tone_saturation();
    timed_t             e;
    logic signed [63:0] want;
    int                 run;
    bit                 done;
    run  = 0;
    done = 1'b0;
    bus32.key_mask = 10'b00_0010_0000;
    bus16.key_mask = 10'b11_0000_0000;
    exp_q.push_back(64'sd56818);
    exp_q.push_back(-64'sd2500000);
    sb_q.push_back('{t: 3,     v: 64'sd20000});
    sb_q.push_back('{t: 4,     v: 64'sd32767});
    sb_q.push_back('{t: 37925, v: 64'sd32767});
    sb_q.push_back('{t: 37926, v: 64'sd0});
    sb_q.push_back('{t: 42568, v: 64'sd0});
    sb_q.push_back('{t: 42569, v: -64'sd32768});
    for (int t = 1; t <= 56825; t++) begin
      tick();
      if (sb_q.size() > 0 && sb_q[0].t == t) begin
        e = sb_q.pop_front();
        checks++;
        if (bus16.sample !== e.v) begin errors++; $display("FAIL sat16_t%0d got=%0d want=%0d", t, bus16.sample, e.v); end
      end
      if (t == 2) begin
        checks++; if (bus32.sample !== 32'sd0) begin errors++; $display("FAIL a4_latency got=%0d want=0", bus32.sample); end
      end
      if (t == 3) begin
        checks++; if (bus32.sample !== 32'sd2500000) begin errors++; $display("FAIL a4_first got=%0d want=2500000", bus32.sample); end
        checks++; if (bus32.voice_busy !== 4'b0001) begin errors++; $display("FAIL a4_busy got=%b want=0001", bus32.voice_busy); end
        checks++; if (bus16.voice_busy !== 4'b0011) begin errors++; $display("FAIL sat16_busy got=%b want=0011", bus16.voice_busy); end
      end
      if (t >= 3 && !done) begin
        if (bus32.sample == 32'sd2500000) run++;
        else begin
          done = 1'b1;
          want = exp_q.pop_front();
          checks++; if (run !== want) begin errors++; $display("FAIL a4_high_len got=%0d want=%0d", run, want); end
          want = exp_q.pop_front();
          checks++; if (bus32.sample !== want) begin errors++; $display("FAIL a4_low got=%0d want=%0d", bus32.sample, want); end
        end
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL a4_high_len got=%0d want=56818 (no toggle within budget)", run);
      exp_q.delete();
    end
    if (sb_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL sat16_pending got=%0d want=0", sb_q.size());
      sb_q.delete();
    end
    bus32.key_mask = '0;
    bus16.key_mask = '0;
    repeat (4) tick();
    checks++; if (bus32.voice_busy !== 4'b0000) begin errors++; $display("FAIL a4_off_busy got=%b want=0000", bus32.voice_busy); end
    checks++; if (bus16.voice_busy !== 4'b0000) begin errors++; $display("FAIL sat16_off_busy got=%b want=0000", bus16.voice_busy); end
  endtask

  task automatic test_overflow();
    timed_t e;
    bus32.key_mask = 10'h01F;
    sb_q.push_back('{t: 2, v: 64'sd1});
    sb_q.push_back('{t: 3, v: 64'sd3});
    sb_q.push_back('{t: 4, v: 64'sd7});
    sb_q.push_back('{t: 5, v: 64'sd15});
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (sb_q.size() > 0 && sb_q[0].t == t) begin
        e = sb_q.pop_front();
        checks++;
        if (bus32.voice_busy !== e.v[3:0]) begin errors++; $display("FAIL alloc_busy_t%0d got=%b want=%b", t, bus32.voice_busy, e.v[3:0]); end
      end
      if (t == 5) begin
        checks++; if (bus32.overflow !== 1'b0) begin errors++; $display("FAIL overflow_early got=%b want=0", bus32.overflow); end
      end
      if (t == 6) begin
        checks++; if (bus32.overflow !== 1'b1) begin errors++; $display("FAIL overflow_set got=%b want=1", bus32.overflow); end
      end
    end
    // drop key 0: voice 0 frees, then the pending key 4 takes it a cycle later
    bus32.key_mask = 10'h01E;
    tick();
    tick();
    checks++; if (bus32.voice_busy !== 4'b1110) begin errors++; $display("FAIL free_busy got=%b want=1110", bus32.voice_busy); end
    tick();
    checks++; if (bus32.voice_busy !== 4'b1111) begin errors++; $display("FAIL regrant_busy got=%b want=1111", bus32.voice_busy); end
    bus32.key_mask = '0;
    repeat (3) tick();
    checks++; if (bus32.voice_busy !== 4'b0000) begin errors++; $display("FAIL alloc_off_busy got=%b want=0000", bus32.voice_busy); end
    checks++; if (bus32.overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got=%b want=1", bus32.overflow); end
  endtask

  task automatic test_two_voice();
    logic signed [63:0] e;
    bus32.key_mask = 10'b00_1100_0000;
    exp_q.push_back(64'sd2500000);
    exp_q.push_back(64'sd5000000);
    repeat (3) tick();
    e = exp_q.pop_front();
    checks++; if (bus32.sample !== e) begin errors++; $display("FAIL two_first got=%0d want=%0d", bus32.sample, e); end
    checks++; if (bus32.voice_busy !== 4'b0011) begin errors++; $display("FAIL two_busy got=%b want=0011", bus32.voice_busy); end
    tick();
    e = exp_q.pop_front();
    checks++; if (bus32.sample !== e) begin errors++; $display("FAIL two_sum got=%0d want=%0d", bus32.sample, e); end
    bus32.key_mask = '0;
    repeat (4) tick();
    checks++; if (bus32.sample !== 32'sd0) begin errors++; $display("FAIL two_off got=%0d want=0", bus32.sample); end
  endtask

  task automatic test_backpressure();
    logic signed [63:0] e;
    int bad;
    bad = 0;
    bus32.sample_ready = 1'b0;
    bus32.key_mask = 10'h004;
    for (int t = 0; t < 100; t++) begin
      tick();
      if (bus32.sample !== 32'sd0 || bus32.sample_valid !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL hold_stable got=%0d changed cycles want=0", bad); end
    exp_q.push_back(64'sd2500000);
    bus32.sample_ready = 1'b1;
    tick();
    e = exp_q.pop_front();
    checks++; if (bus32.sample !== e) begin errors++; $display("FAIL ready_load got=%0d want=%0d", bus32.sample, e); end
    checks++; if (bus32.sample_valid !== 1'b1) begin errors++; $display("FAIL ready_valid got=%b want=1", bus32.sample_valid); end
    bus32.key_mask = '0;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_tone_saturation();
    test_overflow();
    test_two_voice();
    test_backpressure();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
